// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT keypoint output path: image geometry,
// keypoint entry field positions, output word layout and the streamer state encoding.
package sift_pkg;

  localparam int IMG_ROWS     = 480;
  localparam int IMG_COLS     = 640;

  localparam int KPT_ADDR_W   = 10;
  localparam int KPT_DATA_W   = 19;

  localparam int KPT_ROW_MSB  = 18;
  localparam int KPT_ROW_LSB  = 10;
  localparam int KPT_COL_MSB  = 9;
  localparam int KPT_COL_LSB  = 0;
  localparam int KPT_ROW_W    = KPT_ROW_MSB - KPT_ROW_LSB + 1;
  localparam int KPT_COL_W    = KPT_COL_MSB - KPT_COL_LSB + 1;

  // Output word layout
  localparam int WORD_W         = 16;
  localparam int WORD_LAYER_BIT = 15;
  localparam int WORD_ROW_LSB   = 0;
  localparam int WORD_COL_LSB   = 0;
  localparam int HDR_CNT_W      = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR1 = 3'd1,
    ST_RD1  = 3'd2,
    ST_W0   = 3'd3,
    ST_W1   = 3'd4,
    ST_HDR2 = 3'd5,
    ST_RD2  = 3'd6,
    ST_CSUM = 3'd7
  } kpt_state_e;

  // Which half of a keypoint entry a data word carries
  typedef enum logic {
    PH_ROW = 1'b0,
    PH_COL = 1'b1
  } kpt_phase_e;

endpackage

// File: rtl/kpt_stream_out_if.sv
// Valid/ready word stream from the keypoint serialiser to the CORE output port.
interface kpt_stream_out_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/kpt_word_fmt.sv
// Combinational formatter: one keypoint entry plus layer and phase -> one 16-bit stream word.
// Row phase: {layer, 6'b0, row[8:0]}; column phase: {6'b0, col[9:0]}.
module kpt_word_fmt
  import sift_pkg::*;
(
  input  logic                  i_layer,
  input  logic [KPT_DATA_W-1:0] i_entry,
  input  kpt_phase_e            i_phase,
  output logic [WORD_W-1:0]     o_word
);

  // Place the selected entry field into its word position
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    o_word = '0;
    if (i_phase == PH_ROW) begin
      o_word[WORD_LAYER_BIT]               = i_layer;
      o_word[WORD_ROW_LSB +: KPT_ROW_W]    = i_entry[KPT_ROW_MSB:KPT_ROW_LSB];
    end else begin
      o_word[WORD_COL_LSB +: KPT_COL_W]    = i_entry[KPT_COL_MSB:KPT_COL_LSB];
    end
  end

endmodule

// File: rtl/kpt_stream_out.sv
// Keypoint streamer: after detection completes, reads the layer-1 and layer-2
// keypoint memories and serialises header + (row, col) word pairs per layer
// onto a valid/ready stream.
// Optional feature macro: KPT_STREAM_CSUM_EN appends a 16-bit XOR checksum word.
module kpt_stream_out
  import sift_pkg::*;
#(
  parameter int KPT_AW = KPT_ADDR_W,
  parameter int KPT_DW = KPT_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KPT_AW:0]     kpt1_num,
  input  logic [KPT_AW:0]     kpt2_num,
  output logic                kpt_rd_en,
  output logic                kpt_sel,
  output logic [KPT_AW-1:0]   kpt_addr,
  input  logic [KPT_DW-1:0]   kpt_rdata,
  output logic                busy,
  output logic                done,
  kpt_stream_out_if.master    str_if
);

  localparam logic [KPT_AW:0] NUM_ONE = (KPT_AW+1)'(1);

`ifdef KPT_STREAM_CSUM_EN
  localparam kpt_state_e ST_AFTER_L2    = ST_CSUM;
  localparam logic       FINAL_AFTER_L2 = 1'b0;
`else
  localparam kpt_state_e ST_AFTER_L2    = ST_IDLE;
  localparam logic       FINAL_AFTER_L2 = 1'b1;
`endif

  kpt_state_e          r_state, w_next;
  logic [KPT_AW:0]     r_num1, r_num2, w_num;
  logic [KPT_AW-1:0]   r_idx;
  logic                r_layer;
  logic                r_fresh;     // kpt_rdata carries the entry this cycle
  logic                r_done;
  logic [KPT_DW-1:0]   r_entry, w_entry;
  logic [WORD_W-1:0]   w_word, w_fmt_word;
  logic                w_valid, w_xfer, w_last, w_final, w_rd_en, w_sel;
  kpt_phase_e          w_phase;
`ifdef KPT_STREAM_CSUM_EN
  logic [WORD_W-1:0]   r_csum;
`endif

  // First W0 cycle takes the entry straight from memory; afterwards the held copy keeps the word stable
  assign w_entry = r_fresh ? kpt_rdata : r_entry;
  assign w_num   = r_layer ? r_num2 : r_num1;
  assign w_last  = ({1'b0, r_idx} == (w_num - NUM_ONE));
  assign w_xfer  = w_valid & str_if.out_ready;
  assign w_phase = (r_state == ST_W1) ? PH_COL : PH_ROW;

  kpt_word_fmt u_fmt (
    .i_layer (r_layer),
    .i_entry (w_entry),
    .i_phase (w_phase),
    .o_word  (w_fmt_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and stream/memory outputs; the FSM moves on only when the current word transfers
  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_word  = '0;
    w_rd_en = 1'b0;
    w_sel   = 1'b0;
    w_final = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_HDR1;
      ST_HDR1: begin
        w_valid = 1'b1;
        w_word  = {1'b0, HDR_CNT_W'(r_num1)};
        if (str_if.out_ready) w_next = (r_num1 == '0) ? ST_HDR2 : ST_RD1;
      end
      ST_RD1: begin
        w_rd_en = 1'b1;
        w_next  = ST_W0;
      end
      ST_W0: begin
        w_valid = 1'b1;
        w_word  = w_fmt_word;
        if (str_if.out_ready) w_next = ST_W1;
      end
      ST_W1: begin
        w_valid = 1'b1;
        w_word  = w_fmt_word;
        if (str_if.out_ready) begin
          if (!w_last)      w_next = r_layer ? ST_RD2 : ST_RD1;
          else if (!r_layer) w_next = ST_HDR2;
          else begin
            w_next  = ST_AFTER_L2;
            w_final = FINAL_AFTER_L2;
          end
        end
      end
      ST_HDR2: begin
        w_valid = 1'b1;
        w_word  = {1'b0, HDR_CNT_W'(r_num2)};
        if (str_if.out_ready) begin
          if (r_num2 == '0) begin
            w_next  = ST_AFTER_L2;
            w_final = FINAL_AFTER_L2;
          end else begin
            w_next  = ST_RD2;
          end
        end
      end
      ST_RD2: begin
        w_rd_en = 1'b1;
        w_sel   = 1'b1;
        w_next  = ST_W0;
      end
`ifdef KPT_STREAM_CSUM_EN
      ST_CSUM: begin
        w_valid = 1'b1;
        w_word  = r_csum;
        if (str_if.out_ready) begin
          w_next  = ST_IDLE;
          w_final = 1'b1;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Counts, index, layer, entry hold register, done pulse and optional checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num1  <= '0;
      r_num2  <= '0;
      r_idx   <= '0;
      r_layer <= 1'b0;
      r_fresh <= 1'b0;
      r_done  <= 1'b0;
      // NOTE: r_entry is a single holding register, not a memory array, so it is reset like any other flop.
      r_entry <= '0;
`ifdef KPT_STREAM_CSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_done  <= w_final;
      r_fresh <= w_rd_en;
      if (r_fresh) r_entry <= kpt_rdata;
      case (r_state)
        ST_IDLE: if (start) begin
          r_num1  <= kpt1_num;
          r_num2  <= kpt2_num;
          r_idx   <= '0;
          r_layer <= 1'b0;
        end
        ST_W1:   if (w_xfer) r_idx <= w_last ? '0 : r_idx + KPT_AW'(1);
        ST_HDR2: if (w_xfer) r_layer <= 1'b1;
        default: ;
      endcase
`ifdef KPT_STREAM_CSUM_EN
      if (r_state == ST_IDLE && start)        r_csum <= '0;
      else if (w_xfer && r_state != ST_CSUM)  r_csum <= r_csum ^ w_word;
`endif
    end
  end

  assign kpt_rd_en        = w_rd_en;
  assign kpt_sel          = w_sel;
  assign kpt_addr         = r_idx;
  assign busy             = (r_state != ST_IDLE);
  assign done             = r_done;
  assign str_if.out_valid = w_valid;
  assign str_if.out_data  = w_word;

endmodule
